// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package core_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MULDIV      = 2'd1,
      REDIR_DRAIN = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic stall;
      logic flush;
   } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the E-stage load and the D-stage sources.
module hazard_detect
   import core_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] d_rs1,
   input  logic [REG_W-1:0] d_rs2,
   input  logic             d_use_rs1,
   input  logic             d_use_rs2,
   input  logic [REG_W-1:0] e_rd,
   input  logic             e_reg_write,
   input  logic             e_is_load,
   output logic             load_use_c
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit    = d_use_rs1 & (d_rs1 == e_rd);
      rs2_hit    = d_use_rs2 & (d_rs2 == e_rd);
      load_use_c = e_is_load & e_reg_write & (e_rd != REG_ZERO) & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: priority-encoded stall/flush generation,
// mul/div occupancy sequencing and redirect drain for the 6-stage core.
module hazard_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = 4,
   parameter int unsigned CNT_W      = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] d_rs1,
   input  logic [REG_W-1:0] d_rs2,
   input  logic             d_use_rs1,
   input  logic             d_use_rs2,
   input  logic [REG_W-1:0] e_rd,
   input  logic             e_reg_write,
   input  logic             e_is_load,
   input  logic             e_is_muldiv,
   input  logic             e_redirect,
   input  logic             imem_ready,
   input  logic             m_mem_req,
   input  logic             dmem_ready,
   output logic             pc_stall,
   output logic             pc_redirect,
   output logic             f1_f2_stall,
   output logic             f1_f2_flush,
   output logic             f2_d_stall,
   output logic             f2_d_flush,
   output logic             d_e_stall,
   output logic             d_e_flush,
   output logic             e_m_stall,
   output logic             e_m_flush,
   output logic             m_w_flush,
   output logic             muldiv_busy,
   output logic [CNT_W-1:0] perf_stall_cnt
);

   localparam int unsigned MD_CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
   localparam logic [MD_CNT_W-1:0] MD_INIT = MD_CNT_W'(MULDIV_LAT - 2);

   ctrl_state_e         state;
   ctrl_state_e         state_nxt;
   logic [MD_CNT_W-1:0] cnt;
   logic [MD_CNT_W-1:0] cnt_nxt;

   logic       dwait;
   logic       mdbusy;
   logic       md_release;
   logic       load_use;
   logic       pc_hold;
   logic       redirect;
   logic       busy;
   logic       mw_bubble;
   pipe_ctrl_t f1_f2;
   pipe_ctrl_t f2_d;
   pipe_ctrl_t d_e;
   pipe_ctrl_t e_m;

   hazard_detect u_hazard_detect (
      .d_rs1       (d_rs1),
      .d_rs2       (d_rs2),
      .d_use_rs1   (d_use_rs1),
      .d_use_rs2   (d_use_rs2),
      .e_rd        (e_rd),
      .e_reg_write (e_reg_write),
      .e_is_load   (e_is_load),
      .load_use_c  (load_use)
   );

   // Raw hazard conditions from registered state and live inputs
   always_comb begin
      dwait      = m_mem_req & ~dmem_ready;
      md_release = (state == MULDIV) && (cnt == '0);
      mdbusy     = ((state == RUN) && e_is_muldiv) || ((state == MULDIV) && (cnt != '0));
   end

   // State register and mul/div occupancy counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state: a deferred (lower-priority) event never changes state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (!dwait) begin
               if (e_is_muldiv) begin
                  state_nxt = MULDIV;
                  cnt_nxt   = MD_INIT;
               end else if (e_redirect && !imem_ready) begin
                  state_nxt = REDIR_DRAIN;
               end
            end
         end
         MULDIV: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - MD_CNT_W'(1);
            end
            // Released instruction leaves E; its muldiv flag must not retrigger
            if (md_release && !dwait) begin
               state_nxt = (e_redirect && !imem_ready) ? REDIR_DRAIN : RUN;
            end
         end
         REDIR_DRAIN: begin
            state_nxt = imem_ready ? RUN : REDIR_DRAIN;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Priority encoder: only the highest active condition acts this cycle
   always_comb begin
      pc_hold   = 1'b0;
      redirect  = 1'b0;
      busy      = 1'b0;
      mw_bubble = 1'b0;
      f1_f2     = '0;
      f2_d      = '0;
      d_e       = '0;
      e_m       = '0;

      if (dwait) begin
         pc_hold     = 1'b1;
         f1_f2.stall = 1'b1;
         f2_d.stall  = 1'b1;
         d_e.stall   = 1'b1;
         e_m.stall   = 1'b1;
         mw_bubble   = 1'b1;
      end else if (mdbusy) begin
         pc_hold     = 1'b1;
         f1_f2.stall = 1'b1;
         f2_d.stall  = 1'b1;
         d_e.stall   = 1'b1;
         e_m.flush   = 1'b1;
         busy        = 1'b1;
      end else if (e_redirect) begin
         redirect    = 1'b1;
         f1_f2.flush = 1'b1;
         f2_d.flush  = 1'b1;
         d_e.flush   = 1'b1;
      end else if (load_use) begin
         pc_hold     = 1'b1;
         f1_f2.stall = 1'b1;
         f2_d.stall  = 1'b1;
         d_e.flush   = 1'b1;
      end else if (!imem_ready) begin
         pc_hold     = 1'b1;
         f1_f2.flush = 1'b1;
      end

      // Squash the wrong-path fetch still in flight after a redirect
      if (state == REDIR_DRAIN) begin
         pc_hold     = 1'b0;
         f1_f2.flush = 1'b1;
      end
   end

   // Output stage: flush wins over stall on a register; reset forces bubbles
   always_comb begin
      pc_stall    = pc_hold;
      pc_redirect = redirect;
      f1_f2_stall = f1_f2.stall & ~f1_f2.flush;
      f1_f2_flush = f1_f2.flush;
      f2_d_stall  = f2_d.stall & ~f2_d.flush;
      f2_d_flush  = f2_d.flush;
      d_e_stall   = d_e.stall & ~d_e.flush;
      d_e_flush   = d_e.flush;
      e_m_stall   = e_m.stall & ~e_m.flush;
      e_m_flush   = e_m.flush;
      m_w_flush   = mw_bubble;
      muldiv_busy = busy;

      if (rst) begin
         pc_stall    = 1'b0;
         pc_redirect = 1'b0;
         f1_f2_stall = 1'b0;
         f1_f2_flush = 1'b1;
         f2_d_stall  = 1'b0;
         f2_d_flush  = 1'b1;
         d_e_stall   = 1'b0;
         d_e_flush   = 1'b1;
         e_m_stall   = 1'b0;
         e_m_flush   = 1'b1;
         m_w_flush   = 1'b1;
         muldiv_busy = 1'b0;
      end
   end

   // Count of PC-hold cycles, free-running wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
      end else if (pc_stall) begin
         perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline hazard and sequencing controller for the 6-stage RISC-V core (F1, F2, D, E, M, W). It generates the per-register stall/flush pairs for the F1/F2, F2/D, D/E, E/M and M/W pipeline registers, plus PC hold and redirect select. It resolves load-use hazards, fetch and data-memory wait states, E-stage branch/jump redirects, and a fixed-latency multi-cycle mul/div in E with an internal counter. Pipeline registers give stall priority over flush; this block never asserts both on one register in the same cycle.

Parameters:
MULDIV_LAT, 4, E-stage occupancy in cycles of a mul/div instruction (>=2)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
d_rs1  in  5  D-stage source register 1
d_rs2  in  5  D-stage source register 2
d_use_rs1  in  1  D instruction reads rs1
d_use_rs2  in  1  D instruction reads rs2
e_rd  in  5  E-stage destination register
e_reg_write  in  1  E instruction writes rd
e_is_load  in  1  E instruction is a load
e_is_muldiv  in  1  E instruction is mul/div
e_redirect  in  1  E resolved taken branch/jump or mispredict
imem_ready  in  1  instruction memory returns data this cycle
m_mem_req  in  1  M instruction accesses data memory
dmem_ready  in  1  data memory completes this cycle
pc_stall  out  1  hold PC
pc_redirect  out  1  PC loads E-computed target
f1_f2_stall / f1_f2_flush  out  1 each
f2_d_stall / f2_d_flush  out  1 each
d_e_stall / d_e_flush  out  1 each
e_m_stall / e_m_flush  out  1 each
m_w_flush  out  1  bubble into W
muldiv_busy  out  1  mul/div counting in E
perf_stall_cnt  out  CNT_W  cycles with pc_stall=1

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1: state=RUN, counter=0, perf_stall_cnt=0, all stalls 0, all flushes 1, pc_redirect 0.
- Outputs are combinational from registered state and current inputs (zero-latency). State, counter and perf_stall_cnt are registered.
- States: RUN, MULDIV, REDIR_DRAIN.
- Per-cycle condition priority, highest first:
  1. DWAIT: m_mem_req & ~dmem_ready. Stall pc, f1_f2, f2_d, d_e, e_m; m_w_flush=1.
  2. MDBUSY: (state=RUN & e_is_muldiv) or (state=MULDIV & cnt!=0). Stall pc, f1_f2, f2_d, d_e; e_m_flush=1; muldiv_busy=1.
  3. REDIR: e_redirect. pc_redirect=1; flush f1_f2, f2_d, d_e.
  4. LOADUSE: e_is_load & e_reg_write & e_rd!=0 & ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)). Stall pc, f1_f2, f2_d; d_e_flush=1.
  5. IWAIT: ~imem_ready. pc_stall=1; f1_f2_flush=1.
- Conditions with lower priority are ignored that cycle. Their inputs stay asserted because the instructions are held, so they are re-evaluated next cycle.
- MULDIV sequencing:
  - In RUN with e_is_muldiv and no DWAIT: go to MULDIV, cnt=MULDIV_LAT-2.
  - In MULDIV: cnt decrements each cycle, including during DWAIT. It saturates at 0.
  - In MULDIV with cnt==0: E instruction is released (no MDBUSY stall). Next state is RUN only if no DWAIT that cycle; otherwise hold MULDIV, cnt=0.
  - The released mul/div must not retrigger. e_is_muldiv is ignored in the cycle MULDIV exits.
  - Net E occupancy: exactly MULDIV_LAT cycles absent DWAIT.
- REDIR_DRAIN: on REDIR with imem_ready=0, enter REDIR_DRAIN. While in it, f1_f2_flush=1 and pc_stall=0, so the wrong-path fetch in flight is squashed. Exit to RUN on the first cycle imem_ready=1, which is also flushed. A second e_redirect while draining restarts the drain and reasserts pc_redirect.
- Never stall and flush the same register. When a flush rule and a stall rule both target one register, the stall is dropped.
- perf_stall_cnt increments when pc_stall=1 and wraps at 2^CNT_W.
- Reset mid-MULDIV or mid-drain returns to RUN immediately; counter cleared.

Decomposition:
- Package core_ctrl_pkg: ctrl_state_e enum (RUN, MULDIV, REDIR_DRAIN); pipe_ctrl_t struct {stall, flush}; REG_ZERO=5'd0.
- One sub-module, hazard_detect: purely combinational load-use compare, producing the LOADUSE flag.
- FSM, counter and priority encoder stay in hazard_ctrl.

Test Plan:
- Load-use: E=lw x5, D uses rs2=x5 -> one cycle pc/f1_f2/f2_d stall=1, d_e_flush=1; next cycle all 0. With e_rd=x0 -> no stall.
- Mul/div, MULDIV_LAT=4: e_is_muldiv held -> muldiv_busy high for 3 cycles, e_m_flush=1 for 3 cycles, released 4th cycle. No retrigger.
- Redirect with imem_ready=0 for 2 cycles: pc_redirect pulse; f1_f2_flush=1 for 3 cycles total; then state RUN.
- Redirect concurrent with DWAIT: no pc_redirect while dmem_ready=0; m_w_flush=1. pc_redirect fires the cycle dmem_ready=1.
- DWAIT during MULDIV with cnt reaching 0: E held until dmem_ready=1, then released once. perf_stall_cnt equals total pc_stall cycles.
- Assert rst mid-MULDIV: all flushes=1, stalls=0, perf_stall_cnt=0 asynchronously; after release, behaviour is as from cold.
